bus_rx_endpoint: RTL
====================

Name: bus_rx_endpoint

Overview:
- Receive-side endpoint attached to one device port of the bus generator/arbiter (bs_gnrtr_n_rbtr): consumes that port's push / D_push strobes.
- Filters packets by destination ID, buffers accepted packets in a first-word-fall-through FIFO, and presents them to the local consumer over a valid/ready handshake.
- The bus has no backpressure, so overflow packets are dropped and counted.
- The bus instantiates one endpoint per device; it is the hardware counterpart to the transmit-side FIFO that supplies pndng / D_pop.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- depth, 8, FIFO entries; must be a power of 2 and at least 2.
- dev_id, 0, this endpoint's 8-bit device ID.
- broadcast, {8{1'b1}}, destination ID accepted by every endpoint.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  bus strobe; D_push is valid in this cycle.
- D_push  input  pckg_sz  packet from the bus.
- rx_data  output  pckg_sz  head-of-FIFO packet.
- rx_valid  output  1  rx_data is valid.
- rx_ready  input  1  consumer accepts the head packet.
- full  output  1  FIFO holds depth entries.
- count  output  $clog2(depth)+1  current occupancy.
- drop_cnt  output  16  saturating count of matching packets lost to overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - rd_ptr = wr_ptr = 0; count = 0; full = 0; rx_valid = 0; drop_cnt = 0.
  - rx_data is don't-care, but drives 0 after reset.
  - Reset asserted mid-stream discards all buffered packets immediately; no partial state survives.
- Address match:
  - match = (D_push[pckg_sz-1 -: 8] == dev_id) || (D_push[pckg_sz-1 -: 8] == broadcast).
  - Non-matching pushes are ignored silently: no store, no count change, no drop.
- Pop:
  - pop = rx_valid && rx_ready.
  - rx_data must stay stable while rx_valid=1 and rx_ready=0.
- Write accept:
  - wr_en = push && match && (!full || pop).
  - A push to a full FIFO in the same cycle as a pop is accepted; count stays at depth.
- Drop: push && match && full && !pop increments drop_cnt, saturating at 16'hFFFF.
- Pointers: AW = $clog2(depth); pointers are AW+1 bits and wrap naturally.
  - full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
  - empty = (wr_ptr == rd_ptr).
- Count update:
  - +1 on wr_en && !pop; -1 on pop && !wr_en; unchanged when both or neither occur.
  - count is registered and always equals wr_ptr - rd_ptr.
- Latency:
  - A push accepted at edge N into an empty FIFO gives rx_valid=1 and rx_data=D_push after edge N, i.e. visible in cycle N+1.
  - There is no same-cycle bypass.
- Output mode: FWFT; rx_data = mem[rd_ptr[AW-1:0]] and rx_valid = !empty, both derived from registered state.
- Empty FIFO:
  - rx_ready with rx_valid=0 has no effect.
  - Simultaneous push and rx_ready on an empty FIFO: the write occurs and no pop occurs.
- Ordering: packets are delivered strictly in acceptance order, with no reordering between unicast and broadcast packets.
- Unknown values: X on push is treated as no push; assertion-checked in simulation.

Decomposition:
- Shared package bus_pkg holds:
  - localparam ID_W = 8 and BCAST_ID = 8'hFF;
  - the function get_dest(pkt), which extracts the destination field;
  - typedef drop_cnt_t, a 16-bit logic vector.
- The top block contains the address filter, drop counter and handshake logic.
- Sub-module sync_fifo_fwft (parameters width and depth; ports clk, reset, wr_en, wr_data, rd_en, rd_data, empty, full, count) holds the storage and pointers.
- The transmit-side FIFO reuses sync_fifo_fwft.

Test Plan (pckg_sz=16, depth=4, dev_id=8'h03):
- Reset, then push D_push=16'h03AB for one cycle -> next cycle rx_valid=1, rx_data=16'h03AB, count=1; rx_ready=1 for one cycle -> rx_valid=0, count=0.
- Push 16'h0511 (ID 05) -> ignored: rx_valid stays 0, count=0, drop_cnt=0. Push 16'hFF22 (broadcast) -> accepted, rx_data=16'hFF22.
- With rx_ready=0, push 16'h0301..16'h0306 on consecutive cycles -> full=1 after the 4th; drop_cnt=2; draining yields 0301, 0302, 0303, 0304 in order.
- FIFO full, push 16'h0377 with rx_ready=1 in the same cycle -> count stays 4, drop_cnt unchanged, 0377 drains last; pointers wrap correctly past index 3.
- 3 packets buffered, pull reset low asynchronously between clock edges -> rx_valid=0, count=0 immediately; after release, push 16'h0399 -> rx_data=16'h0399.
- Force drop_cnt to 16'hFFFE, then cause 3 overflow drops -> drop_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions for the bus generator/arbiter endpoints.
//   ID_W       : width of the destination ID field (top byte of every packet)
//   BCAST_ID   : destination ID accepted by every endpoint
//   PKT_MAX_W  : widest packet get_dest() can take
//   drop_cnt_t : saturating overflow-drop counter type
//   get_dest() : pull the destination ID out of a packet of pkt_w bits
package bus_pkg;

  localparam int unsigned ID_W      = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int unsigned PKT_MAX_W = 64;

  typedef logic [15:0] drop_cnt_t;

  // Callers zero-extend the packet to PKT_MAX_W; the ID sits in the top ID_W bits of pkt_w.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset, empties the FIFO and clears storage
//   wr_en   : write request; honoured when not full, or when full and a read fires
//   wr_data : data to store
//   rd_en   : read request; ignored while empty
//   rd_data : head entry, valid whenever empty=0 (no same-cycle bypass)
//   empty   : no entries
//   full    : depth entries
//   count   : occupancy, always wr_ptr - rd_ptr
// depth must be a power of two and at least 2.
module sync_fifo_fwft #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [width-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [width-1:0]        rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(depth):0]  count
);

  localparam int unsigned AW = $clog2(depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_count;
  logic [width-1:0] r_mem [depth];
  logic             w_rd_fire;
  logic             w_wr_fire;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_fire = rd_en && !empty;
  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_wr_fire = wr_en && (!full || w_rd_fire);

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign count   = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared so the head reads as 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(depth); i++) r_mem[i] <= '0;
    end else if (w_wr_fire) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/bus_rx_endpoint.sv
// Receive-side bus endpoint: filters pushed packets by destination ID, buffers the accepted
// ones in a FWFT FIFO and hands them to the local consumer over valid/ready.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   push     : bus strobe, D_push valid this cycle
//   D_push   : packet from the bus, destination ID in the top 8 bits
//   rx_data  : head-of-FIFO packet
//   rx_valid : rx_data valid
//   rx_ready : consumer takes the head packet
//   full     : FIFO holds depth entries
//   count    : FIFO occupancy
//   drop_cnt : saturating count of matching packets lost to overflow
module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter int unsigned      pckg_sz   = 16,
  parameter int unsigned      depth     = 8,
  parameter logic [ID_W-1:0]  dev_id    = 8'h00,
  parameter logic [ID_W-1:0]  broadcast = BCAST_ID
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [pckg_sz-1:0]      D_push,
  output logic [pckg_sz-1:0]      rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    full,
  output logic [$clog2(depth):0]  count,
  output drop_cnt_t               drop_cnt
);

  logic [ID_W-1:0] w_dest;
  logic            w_match;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_drop;
  logic            w_empty;
  drop_cnt_t       r_drop_cnt;

  assign w_dest  = get_dest(PKT_MAX_W'(D_push), pckg_sz);
  assign w_match = (w_dest == dev_id) || (w_dest == broadcast);

  assign rx_valid = !w_empty;
  assign w_pop    = rx_valid && rx_ready;
  // The bus cannot be stalled: a matching packet either lands in the FIFO or is dropped.
  assign w_wr_en  = push && w_match && (!full || w_pop);
  assign w_drop   = push && w_match && full && !w_pop;

  sync_fifo_fwft #(
    .width (pckg_sz),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_data (D_push),
    .rd_en   (w_pop),
    .rd_data (rx_data),
    .empty   (w_empty),
    .full    (full),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;

  // An unknown strobe would otherwise be silently read as "no push".
  a_push_known : assert property (@(posedge clk) disable iff (!reset) !$isunknown(push));

endmodule
